// File: rtl/accel_csr_pkg.sv
// Shared types and constants for the Avalon-MM accelerator CSR block.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: FSM state enum, CTRL/STATUS bit indices, CTRL/STATUS offset helpers.
package accel_csr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // CTRL register bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS register bits
  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_DONE_BIT     = 1;
  localparam int STAT_ERR_TO_BIT   = 2;
  localparam int STAT_ERR_LOCK_BIT = 3;

  // CTRL sits directly after the config and result words, STATUS right after CTRL.
  function automatic int ctrl_offset(input int n_cfg, input int n_res);
    return n_cfg + n_res;
  endfunction

  function automatic int status_offset(input int n_cfg, input int n_res);
    return n_cfg + n_res + 1;
  endfunction

endpackage

// File: rtl/csr_be_reg.sv
// DATA_W-bit CSR word with per-byte write enables.
// Latency: write visible the cycle after the enabling edge. Backpressure: none, always accepts.
// Ports: clk_i, rst_ni (async active-low), we_i (write), be_i (byte enables), d_i (data), q_o (contents).
module csr_be_reg #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   q_o
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) q_q[b*8 +: 8] <= d_i[b*8 +: 8];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/avalon_accel_csr.sv
// Avalon-MM CSR front-end for a start/done accelerator: config words, result capture,
// start pulse, busy/watchdog, sticky W1C status and IRQ.
// Latency: writes visible next cycle; reads return data with READDATAVALID exactly one cycle later.
// Backpressure: none; one access per cycle sustained, config writes during a run are dropped and flagged.
// Ports: CLK/RESET (async active-low), AVL_* slave port, CORE_* accelerator handshake/buses,
// IRQ level interrupt, EXPORT_DATA mirror of config word EXPORT_IDX.
module avalon_accel_csr
  import accel_csr_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int N_CFG       = 8,
  parameter int N_RES       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int EXPORT_IDX  = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic                    AVL_CS,
  input  logic [DATA_W/8-1:0]     AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]       AVL_ADDR,
  input  logic [DATA_W-1:0]       AVL_WRITEDATA,
  output logic [DATA_W-1:0]       AVL_READDATA,
  output logic                    AVL_READDATAVALID,
  output logic                    CORE_START,
  input  logic                    CORE_DONE,
  output logic [N_CFG*DATA_W-1:0] CORE_CFG,
  input  logic [N_RES*DATA_W-1:0] CORE_RESULT,
  output logic                    IRQ,
  output logic [DATA_W-1:0]       EXPORT_DATA
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_offset(N_CFG, N_RES));
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(status_offset(N_CFG, N_RES));
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  // ---------------------------------------------------------------------------
  // Strobes and decode
  // ---------------------------------------------------------------------------
  logic wr_stb, rd_stb;
  logic ctrl_wr, stat_wr, start_req;
  logic busy;
  logic [N_CFG-1:0] cfg_hit;
  logic cfg_wr_any;

  assign wr_stb = AVL_WRITE & AVL_CS;
  assign rd_stb = AVL_READ & AVL_CS;

  // CTRL/STATUS bits all live in byte 0, so that byte lane gates their writes.
  assign ctrl_wr   = wr_stb & (AVL_ADDR == CTRL_ADDR) & AVL_BYTE_EN[0];
  assign stat_wr   = wr_stb & (AVL_ADDR == STAT_ADDR) & AVL_BYTE_EN[0];
  assign start_req = ctrl_wr & AVL_WRITEDATA[CTRL_START_BIT];

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_start_q, core_start_d;
  logic              start_lock_err;
  logic              done_evt, timeout_evt;

  assign busy = (state_q == ST_RUN);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_RUN;
      ST_RUN:  if (CORE_DONE || (cnt_q == CNT_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_start_d   = 1'b0;
    cnt_d          = cnt_q;
    start_lock_err = 1'b0;
    done_evt       = 1'b0;
    timeout_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          core_start_d = 1'b1;
          cnt_d        = '0;
        end
      end
      ST_RUN: begin
        start_lock_err = start_req;
        // Completion takes priority over the watchdog in its final cycle.
        done_evt       = CORE_DONE;
        timeout_evt    = ~CORE_DONE & (cnt_q == CNT_LAST);
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q        <= '0;
      core_start_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
    end
  end

  assign CORE_START = core_start_q;

  // ---------------------------------------------------------------------------
  // Config words (locked while busy)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] cfg_w [N_CFG];

  for (genvar i = 0; i < N_CFG; i++) begin : g_cfg
    assign cfg_hit[i] = (AVL_ADDR == ADDR_W'(i));

    csr_be_reg #(.DATA_W(DATA_W)) u_cfg (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .we_i   (wr_stb & cfg_hit[i] & ~busy),
      .be_i   (AVL_BYTE_EN),
      .d_i    (AVL_WRITEDATA),
      .q_o    (cfg_w[i])
    );

    assign CORE_CFG[(N_CFG-1-i)*DATA_W +: DATA_W] = cfg_w[i];
  end

  assign cfg_wr_any  = wr_stb & (|cfg_hit);
  assign EXPORT_DATA = cfg_w[EXPORT_IDX];

  // ---------------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] res_q [N_RES];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int j = 0; j < N_RES; j++) res_q[j] <= '0;
    end else if (done_evt) begin
      for (int j = 0; j < N_RES; j++) res_q[j] <= CORE_RESULT[(N_RES-1-j)*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // CTRL / STATUS (sticky bits: a set in the same cycle as W1C wins)
  // ---------------------------------------------------------------------------
  logic irq_en_q, irq_en_d;
  logic done_q, done_d;
  logic err_to_q, err_to_d;
  logic err_lock_q, err_lock_d;

  always_comb begin
    irq_en_d   = ctrl_wr ? AVL_WRITEDATA[CTRL_IRQ_EN_BIT] : irq_en_q;
    done_d     = (done_q     & ~(stat_wr & AVL_WRITEDATA[STAT_DONE_BIT]))     | done_evt;
    err_to_d   = (err_to_q   & ~(stat_wr & AVL_WRITEDATA[STAT_ERR_TO_BIT]))   | timeout_evt;
    err_lock_d = (err_lock_q & ~(stat_wr & AVL_WRITEDATA[STAT_ERR_LOCK_BIT])) |
                 start_lock_err | (cfg_wr_any & busy);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_lock_q <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
      err_lock_q <= err_lock_d;
    end
  end

  assign IRQ = irq_en_q & (done_q | err_to_q);

  // ---------------------------------------------------------------------------
  // Registered read path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rd_dat_q;
  logic              rd_vld_q;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CFG; i++) begin
      if (AVL_ADDR == ADDR_W'(i)) rd_mux = cfg_w[i];
    end
    for (int j = 0; j < N_RES; j++) begin
      if (AVL_ADDR == ADDR_W'(N_CFG + j)) rd_mux = res_q[j];
    end
    if (AVL_ADDR == CTRL_ADDR) begin
      rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
    end
    if (AVL_ADDR == STAT_ADDR) begin
      rd_mux[STAT_BUSY_BIT]     = busy;
      rd_mux[STAT_DONE_BIT]     = done_q;
      rd_mux[STAT_ERR_TO_BIT]   = err_to_q;
      rd_mux[STAT_ERR_LOCK_BIT] = err_lock_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_dat_q <= rd_stb ? rd_mux : '0;
      rd_vld_q <= rd_stb;
    end
  end

  assign AVL_READDATA      = rd_dat_q;
  assign AVL_READDATAVALID = rd_vld_q;

endmodule

// File: tb/tb_avalon_accel_csr.sv
// Directed self-checking bench for avalon_accel_csr (N_CFG=8, N_RES=4, TIMEOUT_CYC=16).
// Offsets: cfg 0..7, results 8..11, CTRL 12, STATUS 13.
module tb_avalon_accel_csr;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_CFG  = 8;
  localparam int N_RES  = 4;

  logic                    CLK;
  logic                    RESET;
  logic                    AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]              AVL_BYTE_EN;
  logic [ADDR_W-1:0]       AVL_ADDR;
  logic [DATA_W-1:0]       AVL_WRITEDATA;
  logic [DATA_W-1:0]       AVL_READDATA;
  logic                    AVL_READDATAVALID;
  logic                    CORE_START;
  logic                    CORE_DONE;
  logic [N_CFG*DATA_W-1:0] CORE_CFG;
  logic [N_RES*DATA_W-1:0] CORE_RESULT;
  logic                    IRQ;
  logic [DATA_W-1:0]       EXPORT_DATA;

  int errors = 0;
  int checks = 0;

  avalon_accel_csr #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CFG(N_CFG), .N_RES(N_RES),
    .TIMEOUT_CYC(16), .EXPORT_IDX(0)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
    .CORE_START(CORE_START), .CORE_DONE(CORE_DONE),
    .CORE_CFG(CORE_CFG), .CORE_RESULT(CORE_RESULT),
    .IRQ(IRQ), .EXPORT_DATA(EXPORT_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    AVL_WRITE = 1'b1; AVL_CS = 1'b1;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    AVL_ADDR = a; AVL_READ = 1'b1; AVL_CS = 1'b1;
    @(posedge CLK); #1;
    v = AVL_READDATAVALID;
    d = AVL_READDATA;
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    chk({tag, "_vld"}, {31'd0, v}, 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic pulse_done();
    CORE_DONE = 1'b1;
    @(negedge CLK);
    CORE_DONE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0;
    AVL_BYTE_EN = '0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    CORE_DONE = 0; CORE_RESULT = '0;
    #1;
    chk("rst_start", {31'd0, CORE_START}, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_rvalid", {31'd0, AVL_READDATAVALID}, 32'd0);
    chk("rst_rdata", AVL_READDATA, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    rdchk("init_status", 5'd13, 32'h0);

    // Byte-enable write and one-cycle read valid
    wr(5'd2, 32'hAABBCCDD, 4'b0101);
    rdchk("be_read", 5'd2, 32'h00BB00DD);
    @(posedge CLK); #1;
    chk("be_vld_drop", {31'd0, AVL_READDATAVALID}, 32'd0);
    chk("be_rdata_idle", AVL_READDATA, 32'd0);
    @(negedge CLK);
    wr(5'd0, 32'hCAFEF00D, 4'b1111);
    chk("export", EXPORT_DATA, 32'hCAFEF00D);
    chk("cfg_w0", CORE_CFG[255:224], 32'hCAFEF00D);
    chk("cfg_w2", CORE_CFG[191:160], 32'h00BB00DD);
    wr(5'd20, 32'hFFFFFFFF, 4'b1111);
    rdchk("unmapped", 5'd20, 32'h0);

    // Normal run
    wr(5'd12, 32'h2, 4'b1111);
    rdchk("ctrl_irqen", 5'd12, 32'h2);
    CORE_RESULT = {32'h12345678, 32'h2, 32'h3, 32'h4};
    wr(5'd12, 32'h3, 4'b1111);
    chk("start_pulse", {31'd0, CORE_START}, 32'd1);
    @(negedge CLK);
    chk("start_single", {31'd0, CORE_START}, 32'd0);
    rdchk("status_busy", 5'd13, 32'h1);
    pulse_done();
    chk("irq_done", {31'd0, IRQ}, 32'd1);
    rdchk("status_done", 5'd13, 32'h2);
    rdchk("res0", 5'd8, 32'h12345678);
    rdchk("res3", 5'd11, 32'h4);
    wr(5'd13, 32'h2, 4'b1111);
    chk("irq_cleared", {31'd0, IRQ}, 32'd0);
    rdchk("status_clr", 5'd13, 32'h0);

    // Lock while busy
    wr(5'd12, 32'h3, 4'b1111);
    wr(5'd0, 32'h11111111, 4'b1111);
    wr(5'd12, 32'h3, 4'b1111);
    chk("lock_no_start", {31'd0, CORE_START}, 32'd0);
    rdchk("lock_status", 5'd13, 32'h9);
    rdchk("lock_cfg", 5'd0, 32'hCAFEF00D);
    chk("lock_export", EXPORT_DATA, 32'hCAFEF00D);
    pulse_done();
    rdchk("lock_done_status", 5'd13, 32'hA);
    wr(5'd13, 32'hE, 4'b1111);
    rdchk("lock_clr", 5'd13, 32'h0);

    // Watchdog: BUSY/ERR_TIMEOUT change exactly 16 cycles after START
    CORE_RESULT = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    wr(5'd12, 32'h3, 4'b1111);
    repeat (15) @(negedge CLK);
    chk("wd_not_yet", {31'd0, IRQ}, 32'd0);
    @(negedge CLK);
    chk("wd_irq", {31'd0, IRQ}, 32'd1);
    rdchk("wd_status", 5'd13, 32'h4);
    rdchk("wd_res_kept", 5'd8, 32'h12345678);
    wr(5'd13, 32'h4, 4'b1111);

    // CORE_DONE in the watchdog's final cycle
    CORE_RESULT = {32'hAAAA0001, 32'h0, 32'h0, 32'h0};
    wr(5'd12, 32'h3, 4'b1111);
    repeat (15) @(negedge CLK);
    pulse_done();
    rdchk("race_wd_status", 5'd13, 32'h2);
    rdchk("race_wd_res", 5'd8, 32'hAAAA0001);

    // W1C of DONE in the same cycle as CORE_DONE
    wr(5'd12, 32'h3, 4'b1111);
    AVL_ADDR = 5'd13; AVL_WRITEDATA = 32'h2; AVL_BYTE_EN = 4'hF;
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; CORE_DONE = 1'b1;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0; CORE_DONE = 1'b0;
    rdchk("race_w1c_status", 5'd13, 32'h2);
    wr(5'd13, 32'h2, 4'b1111);
    rdchk("race_w1c_clr", 5'd13, 32'h0);

    // Stray CORE_DONE in IDLE
    CORE_RESULT = {32'h55555555, 32'h0, 32'h0, 32'h0};
    pulse_done();
    rdchk("stray_status", 5'd13, 32'h0);
    rdchk("stray_res", 5'd8, 32'hAAAA0001);
    chk("stray_irq", {31'd0, IRQ}, 32'd0);

    // Reset in the middle of a run
    wr(5'd12, 32'h3, 4'b1111);
    pulse_done();
    chk("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    wr(5'd12, 32'h3, 4'b1111);
    chk("pre_rst_start", {31'd0, CORE_START}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_start", {31'd0, CORE_START}, 32'd0);
    chk("mid_rst_irq", {31'd0, IRQ}, 32'd0);
    chk("mid_rst_export", EXPORT_DATA, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    rdchk("post_rst_status", 5'd13, 32'h0);
    rdchk("post_rst_cfg0", 5'd0, 32'h0);
    rdchk("post_rst_res0", 5'd8, 32'h0);
    rdchk("post_rst_ctrl", 5'd12, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
